// File: rtl/mau_drv_pkg.sv
// Shared definitions for the MAU tile pin driver: controller states and the
// Tiny Tapeout pin map of the tile's command/result interface.
package mau_drv_pkg;

    localparam int OP_W          = 3;

    localparam int UI_A_LSB      = 0;
    localparam int UI_B_LSB      = 4;
    localparam int UIO_OP_LSB    = 0;
    localparam int UIO_START_BIT = 3;
    localparam int UIO_DONE_BIT  = 7;

    typedef enum logic [2:0] {
        RESET_DUT,
        IDLE,
        DRIVE,
        WAIT_DONE,
        RESP
    } state_t;

endpackage

// File: rtl/mau_drv_wdog.sv
// Loadable 8-bit down-counter, saturating at zero. Shared between the tile
// reset interval and the done-wait timeout; rst reloads RST_VAL.
module mau_drv_wdog #(
    parameter logic [7:0] RST_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/mau_pin_driver.sv
// Host-side driver for the MAU tile pins: command stream -> pin stimulus -> response
// stream, plus tile reset sequencing. Define MAU_DRV_TIMEOUT_EN to bound WAIT_DONE.
module mau_pin_driver
    import mau_drv_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] dut_ui_in,
    output logic [7:0] dut_uio_in,
    input  logic [7:0] dut_uo_out,
    input  logic [7:0] dut_uio_out,
    input  logic [7:0] dut_uio_oe,
    output logic       dut_ena,
    output logic       dut_rst_n
);

    // Counter holds the remaining cycles minus one, so zero means "last cycle".
    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      a_q, b_q;
    logic [OP_W-1:0] op_q;
    logic [7:0]      data_q;
    logic            done;
    logic            accept, capture, timeout_hit;
    logic            wd_load, wd_dec, wd_zero;
    logic [7:0]      wd_load_val;
    logic            unused_pins;

    assign done        = dut_uio_out[UIO_DONE_BIT] & dut_uio_oe[UIO_DONE_BIT];
    assign unused_pins = ^{dut_uio_out[6:0], dut_uio_oe[6:0]};

    mau_drv_wdog #(
        .RST_VAL (RST_LOAD)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (wd_load_val),
        .dec      (wd_dec),
        .zero     (wd_zero)
    );

    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_DUT;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        wd_load     = 1'b0;
        wd_load_val = RST_LOAD;
        wd_dec      = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            RESET_DUT: begin
                if (wd_zero) state_nxt = IDLE;
                else         wd_dec    = 1'b1;
            end
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = WAIT_DONE;
`ifdef MAU_DRV_TIMEOUT_EN
                wd_load     = 1'b1;
                wd_load_val = 8'(TIMEOUT - 1);
`endif
            end
            WAIT_DONE: begin
                // A done on the final allowed cycle wins over the timeout.
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef MAU_DRV_TIMEOUT_EN
                else if (wd_zero) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end else begin
                    wd_dec = 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = RESET_DUT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
            if (capture)          data_q <= dut_uo_out;
            else if (timeout_hit) data_q <= '0;
        end
    end

`ifdef MAU_DRV_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)              err_q <= 1'b0;
        else if (capture)     err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
    end

    assign rsp_err = err_q;
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        dut_ui_in                          = '0;
        dut_ui_in[UI_A_LSB +: 4]           = a_q;
        dut_ui_in[UI_B_LSB +: 4]           = b_q;
        dut_uio_in                         = '0;
        dut_uio_in[UIO_OP_LSB +: OP_W]     = op_q;
        dut_uio_in[UIO_START_BIT]          = (state == DRIVE);
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign dut_rst_n = (state != RESET_DUT);
    assign dut_ena   = 1'b1;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_mau_pin_driver.sv
// Self-checking bench for mau_pin_driver: table-driven transactions, randomized
// transactions against a cycle-arithmetic model, and reset/timeout corner sequences.
module tb_mau_pin_driver;

    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [7:0] dut_ui_in;
    logic [7:0] dut_uio_in;
    logic [7:0] dut_uo_out = '0;
    logic [7:0] dut_uio_out = '0;
    logic [7:0] dut_uio_oe = '0;
    logic       dut_ena;
    logic       dut_rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    mau_pin_driver #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .dut_ui_in   (dut_ui_in),
        .dut_uio_in  (dut_uio_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe),
        .dut_ena     (dut_ena),
        .dut_rst_n   (dut_rst_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation still running, required to finish");
        $fatal(1, "global watchdog expired");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        int         done_from;
        int         oe_from;
        logic [7:0] uo;
        int         bp;
        bit         pulse;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counting from the accept cycle as 0: DRIVE is cycle 1, WAIT_DONE starts at
    // cycle 2, capture happens in the first WAIT_DONE cycle where done and oe are
    // both high, and rsp_valid appears the cycle after the capture.
    function automatic void model(input int done_from, input int oe_from, input logic [7:0] uo,
                                  output logic [7:0] d, output logic e, output int lat);
        int cap;
        cap = (done_from > oe_from) ? done_from : oe_from;
        if (cap < 2) cap = 2;
        d   = uo;
        e   = 1'b0;
        lat = cap + 1;
`ifdef MAU_DRV_TIMEOUT_EN
        // WAIT_DONE may last TIMEOUT cycles: cycles 2 .. TIMEOUT+1.
        if (cap > TIMEOUT + 1) begin
            d   = 8'h00;
            e   = 1'b1;
            lat = TIMEOUT + 2;
        end
`endif
    endfunction

    task automatic tile_quiet();
        dut_uio_out = '0;
        dut_uio_oe  = '0;
        dut_uo_out  = '0;
    endtask

    task automatic drive_tile(input int cyc, input int done_from, input int oe_from,
                              input logic [7:0] uo, input bit pulse);
        logic d, o;
        d = (cyc >= done_from) || (pulse && cyc == 1);
        o = (cyc >= oe_from)   || (pulse && cyc == 1);
        dut_uio_out = {d, 7'($urandom)};
        dut_uio_oe  = {o, 7'($urandom)};
        if (pulse && cyc == 1) dut_uo_out = 8'hAA;
        else if (d)            dut_uo_out = uo;
        else                   dut_uo_out = 8'($urandom);
    endtask

    task automatic do_reset(input int n);
        int low_cnt;
        bit ready_seen, valid_seen;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset dut_rst_n", 32'(dut_rst_n), 32'd0);
        check("reset dut_ena", 32'(dut_ena), 32'd1);
        check("reset dut_ui_in", 32'(dut_ui_in), 32'd0);
        check("reset dut_uio_in", 32'(dut_uio_in), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd1);
        low_cnt    = 0;
        ready_seen = 1'b0;
        valid_seen = 1'b0;
        while (dut_rst_n == 1'b0 && low_cnt < 300) begin
            low_cnt++;
            if (cmd_ready) ready_seen = 1'b1;
            if (rsp_valid) valid_seen = 1'b1;
            @(negedge clk);
        end
        check("reset dut_rst_n low cycles", 32'(low_cnt), 32'(RST_CYCLES));
        check("reset cmd_ready during tile reset", 32'(ready_seen), 32'd0);
        check("reset rsp_valid during tile reset", 32'(valid_seen), 32'd0);
        check("reset cmd_ready after", 32'(cmd_ready), 32'd1);
        check("reset busy after", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the DRIVE cycle; operand inputs are scrambled
    // afterwards so held pins must come from the driver's registers.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n;
        n         = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_op    = 3'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, input int done_from, input int oe_from,
                           input logic [7:0] uo, input int bp, input bit pulse,
                           input logic [7:0] exp_d, input logic exp_e, input int exp_lat);
        int cyc;
        bit seen;
        send_cmd(a, b, op);
        seen = 1'b0;
        cyc  = 1;
        while (cyc <= 200) begin
            drive_tile(cyc, done_from, oe_from, uo, pulse);
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, " drive ui_in"}, 32'(dut_ui_in), 32'({b, a}));
                check({tag, " drive uio_in"}, 32'(dut_uio_in), 32'({4'b0, 1'b1, op}));
            end
            if (cyc == 2) begin
                check({tag, " wait uio_in"}, 32'(dut_uio_in), 32'({4'b0, 1'b0, op}));
                check({tag, " wait ui_in"}, 32'(dut_ui_in), 32'({b, a}));
            end
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " rsp_valid seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            dut_uo_out = 8'($urandom);
            @(negedge clk);
            check({tag, " stall rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " stall rsp_data"}, 32'(rsp_data), 32'(exp_d));
            check({tag, " stall cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, " stall busy"}, 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tile_quiet();
        @(negedge clk);
        check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " post ui_in held"}, 32'(dut_ui_in), 32'({b, a}));
        check({tag, " post uio_in"}, 32'(dut_uio_in), 32'({4'b0, 1'b0, op}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [3:0] ra, rb;
        logic [2:0] rop;
        logic [7:0] ruo, ed;
        logic       ee;
        int         rdone, roe, rbp, el;
        bit         early;

        //            a      b      op    done oe  uo     bp pulse exp_d  err   lat
        vecs[0] = '{4'd3, 4'd5, 3'd1,   4,  4, 8'h0F, 0, 1'b0, 8'h0F, 1'b0,  5};
        vecs[1] = '{4'd3, 4'd5, 3'd1,   4,  4, 8'h0F, 5, 1'b0, 8'h0F, 1'b0,  5};
        vecs[2] = '{4'hF, 4'h0, 3'd7,   1,  1, 8'hA5, 0, 1'b0, 8'hA5, 1'b0,  3};
        vecs[3] = '{4'h0, 4'hF, 3'd0,   2,  2, 8'h5A, 1, 1'b0, 8'h5A, 1'b0,  3};
        vecs[4] = '{4'h9, 4'h6, 3'd2,   2, 12, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, 13};
        vecs[5] = '{4'h1, 4'hE, 3'd4,   6,  1, 8'hC3, 2, 1'b0, 8'hC3, 1'b0,  7};
        vecs[6] = '{4'h7, 4'h8, 3'd3,   5,  5, 8'h66, 0, 1'b1, 8'h66, 1'b0,  6};

        tile_quiet();
        do_reset(3);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                    vecs[i].done_from, vecs[i].oe_from, vecs[i].uo, vecs[i].bp,
                    vecs[i].pulse, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
        end

`ifdef MAU_DRV_TIMEOUT_EN
        run_txn("timeout", 4'h2, 4'h4, 3'd5, 1000, 1000, 8'hEE, 1, 1'b0, 8'h00, 1'b1, TIMEOUT + 2);
        run_txn("done_at_limit", 4'h2, 4'h4, 3'd5, TIMEOUT + 1, 1, 8'h99, 0, 1'b0, 8'h99, 1'b0, TIMEOUT + 2);
        run_txn("done_after_limit", 4'h2, 4'h4, 3'd5, TIMEOUT + 2, 1, 8'h99, 0, 1'b0, 8'h00, 1'b1, TIMEOUT + 2);
`else
        send_cmd(4'h2, 4'h4, 3'd5);
        early = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (rsp_valid) early = 1'b1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("no_timeout rsp_valid seen", 32'(early), 32'd0);
        check("no_timeout busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        do_reset(1);
`endif

        for (int i = 0; i < 20; i++) begin
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rop = 3'($urandom);
            ruo = 8'($urandom);
`ifdef MAU_DRV_TIMEOUT_EN
            rdone = $urandom_range(1, 20);
`else
            rdone = $urandom_range(1, 12);
`endif
            roe = $urandom_range(1, 10);
            rbp = $urandom_range(0, 3);
            model(rdone, roe, ruo, ed, ee, el);
            run_txn($sformatf("rand%0d", i), ra, rb, rop, rdone, roe, ruo, rbp, 1'($urandom), ed, ee, el);
        end

        // Reset pulsed while WAIT_DONE is pending, with a done already on the pins.
        send_cmd(4'hC, 4'h3, 3'd6);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst busy before", 32'(busy), 32'd1);
        check("midrst rsp_valid before", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        dut_uio_out = 8'h80;
        dut_uio_oe  = 8'h80;
        dut_uo_out  = 8'h77;
        do_reset(1);
        early = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) early = 1'b1;
            @(posedge clk);
            #1;
        end
        check("midrst rsp_valid after", 32'(early), 32'd0);
        tile_quiet();
        run_txn("midrst_next", 4'h4, 4'hB, 3'd2, 3, 3, 8'h42, 0, 1'b0, 8'h42, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
